// File: rtl/in_xif.sv
// CORE-V-XIF result-side types used by the FPU model; widths come from X_ID_WIDTH and FLEN defines.
`ifndef X_ID_WIDTH
`define X_ID_WIDTH 4
`endif
`ifndef FLEN
`define FLEN 32
`endif

package in_xif;

  localparam int XIF_ID_W = `X_ID_WIDTH;
  localparam int XIF_FLEN = `FLEN;

  typedef struct packed {
    logic [XIF_ID_W-1:0] id;
    logic [XIF_FLEN-1:0] data;
    logic [4:0]          rd;
    logic                we;
  } x_result_t;

endpackage

// File: rtl/pa_rvfpm.sv
// Shared FPU-model package: result buffer depth default and pointer-width helper.
package pa_rvfpm;

  localparam int XRB_DEFAULT_DEPTH = 4;

  // One extra bit over the address width acts as the wrap bit.
  function automatic int xrb_ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/xrb_ptr_ctrl.sv
// Read/write pointer pair for the result buffer; flush has priority over push and pop.
module xrb_ptr_ctrl
  import pa_rvfpm::*;
#(
  parameter  int DEPTH = XRB_DEFAULT_DEPTH,
  localparam int PW    = xrb_ptr_w(DEPTH)
) (
  input  logic          ck,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  logic          pop,
  output logic [PW-2:0] waddr,
  output logic [PW-2:0] raddr,
  output logic          full,
  output logic          empty,
  output logic [PW-1:0] count
);

  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge ck) begin
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
    end else if (flush) begin
      rptr <= wptr;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
    end
  end

  assign waddr = wptr[PW-2:0];
  assign raddr = rptr[PW-2:0];
  assign empty = (wptr == rptr);
  assign full  = (wptr[PW-2:0] == rptr[PW-2:0]) && (wptr[PW-1] != rptr[PW-1]);
  assign count = wptr - rptr;

endmodule

// File: rtl/xif_result_buffer.sv
// In-order FIFO between the FPU result port and the core; define XIF_RESULT_BYPASS_EN
// to forward a result combinationally when the buffer is empty.
module xif_result_buffer
  import pa_rvfpm::*;
  import in_xif::*;
#(
  parameter int DEPTH      = XRB_DEFAULT_DEPTH,
  parameter int X_ID_WIDTH = `X_ID_WIDTH,
  parameter int FLEN       = `FLEN
) (
  input  logic                   ck,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  x_result_t              in_result,
  output logic                   out_valid,
  input  logic                   out_ready,
  output x_result_t              out_result,
  input  logic                   flush,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow
);

  localparam int PW = xrb_ptr_w(DEPTH);

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("xif_result_buffer: DEPTH must be a power of two >= 2");
  end
  if ($bits(x_result_t) != X_ID_WIDTH + FLEN + 6) begin : g_bad_width
    $error("xif_result_buffer: x_result_t does not match X_ID_WIDTH/FLEN");
  end

  x_result_t     mem [DEPTH];
  logic          full;
  logic          empty;
  logic [PW-2:0] waddr;
  logic [PW-2:0] raddr;
  logic [PW-1:0] occ;
  logic          bypass;
  logic          push;
  logic          pop;

`ifdef XIF_RESULT_BYPASS_EN
  assign bypass = empty && !flush && in_valid && !rst;
`else
  assign bypass = 1'b0;
`endif

  assign in_ready = !full && !rst;

  always_comb begin
    out_valid  = 1'b0;
    out_result = '0;
    if (!rst) begin
      if (!empty) begin
        out_valid  = 1'b1;
        out_result = mem[raddr];
      end else if (bypass) begin
        out_valid  = 1'b1;
        out_result = in_result;
      end
    end
  end

  // A bypassed result that the core takes immediately never occupies a slot.
  assign push  = in_valid && in_ready && !flush && !(bypass && out_ready);
  assign pop   = out_valid && out_ready && !empty && !flush;
  assign count = rst ? '0 : occ;

  xrb_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr_ctrl (
    .ck    (ck),
    .rst   (rst),
    .flush (flush),
    .push  (push),
    .pop   (pop),
    .waddr (waddr),
    .raddr (raddr),
    .full  (full),
    .empty (empty),
    .count (occ)
  );

  // NOTE: the storage array has no reset; validity is tracked by the pointers alone.
  always_ff @(posedge ck) begin
    if (push) mem[waddr] <= in_result;
  end

  always_ff @(posedge ck) begin
    if (rst)                       overflow <= 1'b0;
    else if (in_valid && !in_ready) overflow <= 1'b1;
  end

endmodule

// File: tb/tb_xif_result_buffer.sv
// Self-checking bench for xif_result_buffer: directed scenarios then random traffic against a queue model.
module tb_xif_result_buffer;
  import in_xif::*;

  localparam int DEPTH = 4;
`ifdef XIF_RESULT_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       ck = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  x_result_t  in_result;
  logic       out_valid;
  logic       out_ready;
  x_result_t  out_result;
  logic       flush;
  logic [2:0] count;
  logic       overflow;

  always #5 ck = ~ck;

  xif_result_buffer #(.DEPTH(DEPTH)) dut (
    .ck         (ck),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .flush      (flush),
    .count      (count),
    .overflow   (overflow)
  );

  int        n_checks = 0;
  int        n_fail   = 0;
  x_result_t model_q[$];
  bit        model_ovf = 1'b0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic x_result_t mk(input int id, input logic [31:0] data, input int rd, input bit we);
    x_result_t r;
    r.id   = id[XIF_ID_W-1:0];
    r.data = XIF_FLEN'(data);
    r.rd   = rd[4:0];
    r.we   = we;
    return r;
  endfunction

  // Drive one cycle's inputs, check outputs against the model, then advance the model past the edge.
  task automatic cycle(input logic v, input x_result_t r, input logic ordy, input logic fl, input logic rs);
    bit        exp_ov;
    x_result_t exp_res;
    bit        was_full;
    bit        take;
    bit        do_pop;
    bit        do_push;
    @(negedge ck);
    in_valid  = v;
    in_result = r;
    out_ready = ordy;
    flush     = fl;
    rst       = rs;
    #1;
    exp_ov  = 1'b0;
    exp_res = '0;
    if (!rs) begin
      if (model_q.size() > 0) begin
        exp_ov  = 1'b1;
        exp_res = model_q[0];
      end else if (BYP && v && !fl) begin
        exp_ov  = 1'b1;
        exp_res = r;
      end
    end
    check("in_ready",   in_ready,   !rs && (model_q.size() < DEPTH));
    check("out_valid",  out_valid,  exp_ov);
    check("out_result", out_result, exp_res);
    check("count",      count,      rs ? 0 : model_q.size());
    check("overflow",   overflow,   model_ovf);

    was_full = (model_q.size() == DEPTH);
    if (rs) begin
      model_q.delete();
      model_ovf = 1'b0;
    end else begin
      if (v && was_full) model_ovf = 1'b1;
      if (fl) begin
        model_q.delete();
      end else begin
        take    = BYP && (model_q.size() == 0) && v && ordy;
        do_pop  = (model_q.size() > 0) && ordy;
        do_push = v && !was_full && !take;
        if (do_pop)  void'(model_q.pop_front());
        if (do_push) model_q.push_back(r);
      end
    end
  endtask

  task automatic idle(input logic ordy);
    cycle(1'b0, '0, ordy, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    x_result_t r;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_result = '0;
    out_ready = 1'b0;
    flush     = 1'b0;
    @(posedge ck);

    // Reset held, then released.
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(1'b0);

    // Three results buffered, then drained in order.
    cycle(1'b1, mk(1, 32'h3F800000, 5, 1'b1), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(2, 32'h40000000, 6, 1'b1), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(3, 32'h40400000, 7, 1'b1), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("count_after_3", count, 3);
    repeat (3) idle(1'b1);
    idle(1'b0);

    // Fill, drop a fifth input, drain.
    for (int i = 0; i < 4; i++) cycle(1'b1, mk(10 + i, 32'h1000 + i, 8 + i, 1'b1), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(15, 32'hDEAD, 1, 1'b1), 1'b0, 1'b0, 1'b0);
    idle(1'b0);
    check("overflow_sticky", overflow, 1'b1);
    repeat (4) idle(1'b1);
    idle(1'b0);

    // Steady stream at occupancy 2.
    cycle(1'b1, mk(4, 32'h2000, 2, 1'b0), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(5, 32'h2001, 3, 1'b1), 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) cycle(1'b1, mk(6 + i, 32'h3000 + i, i, i[0]), 1'b1, 1'b0, 1'b0);
    repeat (2) idle(1'b1);
    idle(1'b0);

    // Flush with three buffered and a simultaneous input.
    for (int i = 0; i < 3; i++) cycle(1'b1, mk(1 + i, 32'h4000 + i, 1, 1'b1), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(7, 32'h7777, 7, 1'b1), 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    check("count_after_flush", count, 0);
    idle(1'b1);

    // Empty buffer, input and ready together: bypass or one-cycle latency.
    cycle(1'b1, mk(9, 32'h41100000, 9, 1'b1), 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    idle(1'b0);

    // Reset in the middle of a stream.
    cycle(1'b1, mk(2, 32'h5000, 2, 1'b1), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(3, 32'h5001, 3, 1'b1), 1'b0, 1'b0, 1'b0);
    cycle(1'b1, mk(4, 32'h5002, 4, 1'b1), 1'b1, 1'b0, 1'b1);
    idle(1'b1);

    // Random traffic.
    for (int i = 0; i < 600; i++) begin
      r.id   = XIF_ID_W'($urandom());
      r.data = XIF_FLEN'({$urandom(), $urandom()});
      r.rd   = 5'($urandom());
      r.we   = 1'($urandom());
      cycle(logic'($urandom_range(0, 99) < 60), r,
            logic'($urandom_range(0, 99) < 50),
            logic'($urandom_range(0, 99) < 4),
            logic'($urandom_range(0, 99) < 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
